fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of 2, >= 4).
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_instr[2]  input  32 each  instructions from the i-cache read_instr.
REQ-005 SHALL have port in_valid[2]  input  1 each  per-slot valid from the i-cache valid_read.
REQ-006 SHALL have port in_pc[2]  input  `ADDR_WIDTH each  per-slot PC from the i-cache prev_read_addr.
REQ-007 SHALL have port flush  input  1  pipeline flush.
REQ-008 SHALL have port dec_ready[2]  input  1 each  decode accepts out slot i.
REQ-009 SHALL have port out_instr[2]  output  32 each  instruction to decode.
REQ-010 SHALL have port out_pc[2]  output  `ADDR_WIDTH each  PC to decode.
REQ-011 SHALL have port out_valid[2]  output  1 each  out slot i holds a real entry.
REQ-012 SHALL have port stall_out  output  1  drives the i-cache ext_stall.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 SHALL be a circular buffer, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, each entry {instr, pc}.
REQ-015 SHALL assert stall_out combinationally iff (DEPTH - count) < 2, from registered count only; same-cycle dequeue is not credited.
REQ-016 SHALL accept inputs only when stall_out=0 and flush=0; inputs presented while stall_out=1 are ignored (the i-cache holds and re-presents them).
REQ-017 SHALL compact on enqueue: both valid -> slot0 at tail, slot1 at tail+1; one valid -> that slot at tail; none -> no write.
REQ-018 SHALL drive out slot0 from head and out slot1 from head+1 combinationally; out_valid[0]=(count>=1), out_valid[1]=(count>=2).
REQ-019 SHALL drive out_instr=32'h23 and out_pc=0 on any slot with out_valid=0.
REQ-020 SHALL dequeue n = (out_valid[0]&dec_ready[0]) + (out_valid[1]&dec_ready[1]&dec_ready[0]); dec_ready[1] alone dequeues nothing.
REQ-021 SHALL apply enqueue and dequeue in the same cycle: count_next = count + enq_n - deq_n, no overflow possible given REQ-015.
REQ-022 SHALL, on flush, set head=tail=count=0 next edge, ignoring that cycle's enqueue and dequeue; stall_out is 0 the following cycle.
REQ-023 SHALL deliver an accepted instruction to out slot0 no earlier than one cycle after acceptance (no bypass).
REQ-024 SHALL preserve program order across wrap-around of head and tail.

Reset
REQ-025 SHALL on reset asynchronously clear head, tail, count to 0; hence out_valid=0, out_instr=32'h23, out_pc=0, stall_out=0.
REQ-026 SHALL not reset storage contents; contents are unobservable while out_valid=0.
REQ-027 SHALL discard any in-flight enqueue/dequeue when reset asserts mid-operation.

Structure
REQ-028 SHALL take `ADDR_WIDTH from riscv_core.svh; the bubble encoding 32'h23 SHALL be a shared constant in that header, also used by the i-cache.
REQ-029 SHALL be a single module with no sub-modules; pointer/count logic inline.

Verification
REQ-030 Reset: assert reset mid-stream with count=5 -> count=0, out_valid={0,0}, out_instr=32'h23, stall_out=0 immediately.
REQ-031 Fill: DEPTH=8, dec_ready=0, 2 valid instrs/cycle from PC 0x0 -> stall_out=1 once count=8 after 4 cycles; inputs held during stall not duplicated.
REQ-032 Compaction: in_valid={0,1}, in_instr[1]=0x00500093, pc 0x104 -> next cycle out_valid[0]=1, out_instr[0]=0x00500093, out_pc[0]=0x104, count=1.
REQ-033 Partial dequeue: count=3, dec_ready={1,0} -> count=2, new head PC = old out_pc[1]; dec_ready={0,1} -> count unchanged.
REQ-034 Wrap: 20 cycles of continuous 2-in/2-out from PC 0x0 -> out_pc sequence 0x0,0x4,...,0x9C in order, count constant at 2.
REQ-035 Flush: count=6, flush=1 with in_valid={1,1} and dec_ready={1,1} -> next cycle count=0, out_valid={0,0}, stall_out=0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: constants and types shared between the fetch queue and
// the i-cache side of the front end.
//   ADDR_WIDTH   - width of an instruction address (PC)
//   INSTR_BUBBLE - encoding driven on any slot that carries no instruction;
//                  the i-cache uses the same value for its empty reads
//   fq_entry_t   - one queue entry {instr, pc}
package fetch_queue_pkg;

    localparam int          ADDR_WIDTH   = 32;
    localparam logic [31:0] INSTR_BUBBLE = 32'h23;

    typedef struct packed {
        logic [31:0]           instr;
        logic [ADDR_WIDTH-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: two-wide circular instruction buffer between the i-cache and
// decode. Up to two instructions enter per cycle (compacted so that gaps in
// the input valid mask never leave holes) and up to two leave per cycle, in
// order.
//
// Ports
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset (clears pointers and count)
//   in_instr   - [2] instructions from the i-cache
//   in_valid   - [2] per-slot valid from the i-cache
//   in_pc      - [2] per-slot PC from the i-cache
//   flush      - empties the queue on the next edge
//   dec_ready  - [2] decode accepts out slot i (slot 1 only counts with slot 0)
//   out_instr  - [2] instruction to decode (INSTR_BUBBLE when not valid)
//   out_pc     - [2] PC to decode (0 when not valid)
//   out_valid  - [2] out slot i holds a real entry
//   stall_out  - fewer than two free entries; holds the i-cache
//   count      - current occupancy
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0][31:0]                     in_instr,
    input  logic [1:0]                           in_valid,
    input  logic [1:0][ADDR_WIDTH-1:0]           in_pc,
    input  logic                                 flush,
    input  logic [1:0]                           dec_ready,
    output logic [1:0][31:0]                     out_instr,
    output logic [1:0][ADDR_WIDTH-1:0]           out_pc,
    output logic [1:0]                           out_valid,
    output logic                                 stall_out,
    output logic [$clog2(DEPTH+1)-1:0]           count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Storage carries no reset: it is only visible through out_* when
    // out_valid is set, which requires a write after reset.
    fq_entry_t      mem [DEPTH];

    logic [PW-1:0]  head, tail;
    logic [PW-1:0]  head_p1, tail_p1;
    logic           accept;
    logic [1:0]     enq_n, deq_n;
    fq_entry_t      slot0, slot1;

    // DEPTH is a power of two, so plain pointer arithmetic wraps correctly.
    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);

    // Space check uses the registered count only; entries leaving this
    // cycle do not free room until the next one. That keeps the i-cache
    // handshake off the decode-ready path.
    assign stall_out = (count > CW'(DEPTH - 2));
    assign accept    = !stall_out && !flush;

    assign out_valid[0] = (count >= CW'(1));
    assign out_valid[1] = (count >= CW'(2));

    assign slot0 = mem[head];
    assign slot1 = mem[head_p1];

    always_comb begin
        out_instr[0] = out_valid[0] ? slot0.instr : INSTR_BUBBLE;
        out_pc[0]    = out_valid[0] ? slot0.pc    : '0;
        out_instr[1] = out_valid[1] ? slot1.instr : INSTR_BUBBLE;
        out_pc[1]    = out_valid[1] ? slot1.pc    : '0;
    end

    // Slot 1 may only retire together with slot 0 to keep program order.
    assign deq_n = {1'b0, out_valid[0] & dec_ready[0]}
                 + {1'b0, out_valid[1] & dec_ready[1] & dec_ready[0]};

    assign enq_n = accept ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_n);
            count <= count + CW'(enq_n) - CW'(deq_n);
        end
    end

    // Compacting write: the first valid input always lands at tail, so a
    // lone slot-1 instruction does not leave a hole.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            if (in_valid[0])
                mem[tail] <= '{instr: in_instr[0], pc: in_pc[0]};
            if (in_valid[1])
                mem[in_valid[0] ? tail_p1 : tail] <= '{instr: in_instr[1], pc: in_pc[1]};
        end
    end

endmodule
